jelly2_video_filter_coeff_scheduler: RTL and testbench
======================================================

Name: jelly2_video_filter_coeff_scheduler

Overview:
- Wishbone-master sequencer that reprograms a box/convolution filter core's coefficient registers from a local multi-bank coefficient table.
- On a bank-switch request it writes every coefficient of the selected bank, then the control register, then holds the filter's update request until the next frame start.
- New coefficients therefore take effect on a frame boundary, never mid-frame.
- Sits beside the video filter; its WB master drives the filter's s_wb_* slave and its update_req drives the filter's in_update_req.

Parameters:
- NUM_BANKS, 4, number of coefficient banks.
- BANK_WIDTH, $clog2(NUM_BANKS) (min 1), bank index width.
- COEFF_NUM, 27, coefficients per bank (COMPONENTS*ROWS*COLS).
- INDEX_WIDTH, $clog2(COEFF_NUM), coefficient index width.
- COEFF_WIDTH, 18, signed coefficient width.
- WB_ADR_WIDTH, 8, WB address width.
- WB_DAT_WIDTH, 32, WB data width.
- WB_SEL_WIDTH, WB_DAT_WIDTH/8, WB byte-select width.
- ADR_COEFF0, 8'h40, WB word address of coefficient 0; coefficient i is at ADR_COEFF0+i.
- ADR_CTL, 8'h04, WB word address of the filter control register.
- CTL_VALUE, 32'h3, value written to ADR_CTL (enable + update).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- tbl_we  in  1  coefficient table write strobe.
- tbl_bank  in  BANK_WIDTH  table write bank.
- tbl_index  in  INDEX_WIDTH  table write index.
- tbl_data  in  COEFF_WIDTH  table write data (signed).
- s_req_bank  in  BANK_WIDTH  requested bank.
- s_req_valid  in  1  bank-switch request.
- s_req_ready  out  1  request accepted when valid&ready.
- frame_start  in  1  one-cycle pulse at the first pixel of a frame.
- update_req  out  1  to the filter's in_update_req.
- m_wb_adr_o  out  WB_ADR_WIDTH  WB address.
- m_wb_dat_o  out  WB_DAT_WIDTH  WB write data.
- m_wb_we_o  out  1  always 1 while stb.
- m_wb_sel_o  out  WB_SEL_WIDTH  all ones while stb.
- m_wb_stb_o  out  1  WB strobe.
- m_wb_ack_i  in  1  WB acknowledge.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the new bank becomes active.
- active_bank  out  BANK_WIDTH  last bank committed by a completed sequence.

Behaviour:
- Reset values: state=IDLE, s_req_ready=1, update_req=0, m_wb_stb_o=0, m_wb_adr_o=0, m_wb_dat_o=0, busy=0, done=0, active_bank=0.
- Table contents are not reset.
- Table writes take effect the next cycle in all states.
- A table write to the bank being transferred affects only words not yet issued.
- s_req_ready = (state==IDLE).
- Handshake: in IDLE, s_req_valid=1 latches s_req_bank and sets idx=0; the state moves to WRITE next cycle.
- WRITE:
  - stb=1, adr=ADR_COEFF0+idx, dat=sign-extended table[bank][idx], registered.
  - adr/dat/stb stay stable until ack.
  - On an ack cycle, if idx==COEFF_NUM-1 the state moves to CTL; otherwise idx increments and the next word is presented the following cycle.
  - Back-to-back words are permitted (one word per cycle if ack is combinational).
- CTL: stb=1, adr=ADR_CTL, dat=CTL_VALUE. On ack, stb=0, update_req=1, and the state moves to WAIT_FRAME.
- WAIT_FRAME:
  - update_req holds 1.
  - On frame_start: update_req=0, active_bank=latched bank, done=1 for one cycle, state back to IDLE.
  - s_req_ready=1 again on the cycle after the frame_start.
- frame_start in IDLE, WRITE or CTL is ignored. A frame_start in the same cycle as the CTL ack is also ignored; the block waits for the next one.
- s_req_valid outside IDLE is ignored (not queued). The requester holds valid until ready.
- A request for the current active_bank still runs the full sequence.
- Minimum request-to-update_req latency: COEFF_NUM+2 cycles with single-cycle ack.
- WB ack is sampled only while stb=1; stray acks are ignored.
- No timeout: a missing ack stalls in WRITE/CTL indefinitely with stb held.
- Reset mid-operation: all outputs return to reset values asynchronously, including a stb abandoned mid-cycle. The table retains its data.

Test Plan:
- Load bank 1 with coeff[i]=i-13, request bank 1 with single-cycle ack → 27 writes at adr 0x40..0x5A, dat 0xFFFFFFF3..0x0000000D sign-extended; then 0x04←0x3; update_req=1.
- In WAIT_FRAME, pulse frame_start → update_req falls, done=1 for exactly one cycle, active_bank=1, s_req_ready=1 the next cycle.
- Ack delayed 3 cycles per word → stb/adr/dat stable across the wait, no dropped or duplicated index, 27+1 transfers total.
- s_req_valid with bank 2 asserted during WRITE, and frame_start pulsed during WRITE → both ignored; the sequence completes for the original bank and waits for a later frame_start.
- Assert reset at coefficient 10 → stb=0, busy=0 immediately; a new request then restarts from adr 0x40.
- Overwrite bank 1 index 20 to 0x7 while idx=5 → the word at 0x54 carries 0x00000007.

Source files
------------

// File: rtl/jelly2_video_filter_coeff_scheduler.sv
// jelly2_video_filter_coeff_scheduler: writes a coefficient bank to a filter core over WB, then holds its update request until the next frame start
module jelly2_video_filter_coeff_scheduler #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_WIDTH = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1,
  parameter int COEFF_NUM = 27,
  parameter int INDEX_WIDTH = $clog2(COEFF_NUM),
  parameter int COEFF_WIDTH = 18,
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter logic [WB_ADR_WIDTH-1:0] ADR_COEFF0 = 8'h40,
  parameter logic [WB_ADR_WIDTH-1:0] ADR_CTL = 8'h04,
  parameter logic [WB_DAT_WIDTH-1:0] CTL_VALUE = 32'h3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tbl_we,
  input  logic [BANK_WIDTH-1:0]   tbl_bank,
  input  logic [INDEX_WIDTH-1:0]  tbl_index,
  input  logic [COEFF_WIDTH-1:0]  tbl_data,
  input  logic [BANK_WIDTH-1:0]   s_req_bank,
  input  logic                    s_req_valid,
  output logic                    s_req_ready,
  input  logic                    frame_start,
  output logic                    update_req,
  output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
  output logic                    m_wb_we_o,
  output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
  output logic                    m_wb_stb_o,
  input  logic                    m_wb_ack_i,
  output logic                    busy,
  output logic                    done,
  output logic [BANK_WIDTH-1:0]   active_bank
);
  typedef enum logic [1:0] {IDLE, WRITE, CTL, WAIT_FRAME} state_t;
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(COEFF_NUM - 1);
  state_t state_q, state_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d, active_bank_q, active_bank_d, rd_bank;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d, rd_idx;
  logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;
  logic stb_q, stb_d, update_req_q, update_req_d, done_q, done_d;
  logic [COEFF_WIDTH-1:0] tbl_mem [NUM_BANKS][COEFF_NUM];
  logic [COEFF_WIDTH-1:0] rd_coeff;
  always_ff @(posedge clk)
    if (tbl_we) tbl_mem[tbl_bank][tbl_index] <= tbl_data;
  assign rd_coeff = tbl_mem[rd_bank][rd_idx];
  always_comb begin
    state_d = state_q;
    bank_d = bank_q;
    idx_d = idx_q;
    adr_d = adr_q;
    dat_d = dat_q;
    stb_d = stb_q;
    update_req_d = update_req_q;
    done_d = 1'b0;
    active_bank_d = active_bank_q;
    rd_bank = bank_q;
    rd_idx = '0;
    case (state_q)
      IDLE: if (s_req_valid) begin
        state_d = WRITE;
        bank_d = s_req_bank;
        rd_bank = s_req_bank;
        idx_d = '0;
        stb_d = 1'b1;
        adr_d = ADR_COEFF0;
        dat_d = WB_DAT_WIDTH'($signed(rd_coeff));
      end
      WRITE: if (m_wb_ack_i) begin
        if (idx_q == LAST) begin
          state_d = CTL;
          adr_d = ADR_CTL;
          dat_d = CTL_VALUE;
        end else begin
          rd_idx = idx_q + 1'b1;
          idx_d = rd_idx;
          adr_d = ADR_COEFF0 + WB_ADR_WIDTH'(rd_idx);
          dat_d = WB_DAT_WIDTH'($signed(rd_coeff));
        end
      end
      CTL: if (m_wb_ack_i) begin
        state_d = WAIT_FRAME;
        stb_d = 1'b0;
        adr_d = '0;
        dat_d = '0;
        update_req_d = 1'b1;
      end
      default: if (frame_start) begin
        state_d = IDLE;
        update_req_d = 1'b0;
        done_d = 1'b1;
        active_bank_d = bank_q;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      bank_q <= '0;
      idx_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      stb_q <= 1'b0;
      update_req_q <= 1'b0;
      done_q <= 1'b0;
      active_bank_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q <= bank_d;
      idx_q <= idx_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      stb_q <= stb_d;
      update_req_q <= update_req_d;
      done_q <= done_d;
      active_bank_q <= active_bank_d;
    end
  assign s_req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign update_req = update_req_q;
  assign done = done_q;
  assign active_bank = active_bank_q;
  assign m_wb_adr_o = adr_q;
  assign m_wb_dat_o = dat_q;
  assign m_wb_stb_o = stb_q;
  assign m_wb_we_o = stb_q;
  assign m_wb_sel_o = {WB_SEL_WIDTH{stb_q}};
endmodule

// File: tb/tb_jelly2_video_filter_coeff_scheduler.sv
// tb_jelly2_video_filter_coeff_scheduler: directed self-checking bench for the coefficient scheduler
module tb_jelly2_video_filter_coeff_scheduler;
  logic clk = 1'b0;
  logic reset, tbl_we, s_req_valid, s_req_ready, frame_start, update_req;
  logic m_wb_we_o, m_wb_stb_o, m_wb_ack_i, busy, done;
  logic [1:0] tbl_bank, s_req_bank, active_bank;
  logic [4:0] tbl_index;
  logic [17:0] tbl_data;
  logic [7:0] m_wb_adr_o;
  logic [31:0] m_wb_dat_o;
  logic [3:0] m_wb_sel_o;
  int n_cmp = 0;
  int n_fail = 0;
  int ntx, stable_err;
  logic [7:0] log_adr [64];
  logic [31:0] log_dat [64];
  always #5 clk = ~clk;
  jelly2_video_filter_coeff_scheduler dut (
    .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_bank(tbl_bank), .tbl_index(tbl_index),
    .tbl_data(tbl_data), .s_req_bank(s_req_bank), .s_req_valid(s_req_valid),
    .s_req_ready(s_req_ready), .frame_start(frame_start), .update_req(update_req),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_we_o(m_wb_we_o),
    .m_wb_sel_o(m_wb_sel_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_ack_i(m_wb_ack_i),
    .busy(busy), .done(done), .active_bank(active_bank)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_bank(input logic [1:0] b, input int mul, input int ofs);
    for (int i = 0; i < 27; i++) begin
      tbl_we = 1'b1;
      tbl_bank = b;
      tbl_index = 5'(i);
      tbl_data = 18'(i * mul + ofs);
      step();
    end
    tbl_we = 1'b0;
  endtask
  task automatic request(input logic [1:0] b);
    int c;
    c = 0;
    while (s_req_ready !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    n_cmp++;
    if (s_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_wait: s_req_ready=%b required 1", s_req_ready);
    end
    s_req_valid = 1'b1;
    s_req_bank = b;
    step();
    s_req_valid = 1'b0;
  endtask
  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask
  task automatic serve(input int delay, input int limit, input int act_at, input int kind);
    int w;
    logic pend, fired;
    logic [7:0] padr;
    logic [31:0] pdat;
    w = 0; pend = 1'b0; fired = 1'b0; padr = '0; pdat = '0;
    ntx = 0; stable_err = 0;
    for (int c = 0; c < limit && update_req !== 1'b1; c++) begin
      tbl_we = 1'b0; s_req_valid = 1'b0; frame_start = 1'b0; m_wb_ack_i = 1'b0;
      if (pend && (m_wb_stb_o !== 1'b1 || m_wb_adr_o !== padr || m_wb_dat_o !== pdat)) stable_err++;
      pend = 1'b0;
      if (!fired && kind != 0 && ntx == act_at && m_wb_stb_o === 1'b1) begin
        fired = 1'b1;
        if (kind == 1) begin
          s_req_valid = 1'b1; s_req_bank = 2'd2; frame_start = 1'b1;
        end else if (kind == 2) begin
          tbl_we = 1'b1; tbl_bank = 2'd1; tbl_index = 5'd20; tbl_data = 18'd7;
        end else begin
          reset = 1'b1;
          #1;
          return;
        end
      end
      if (m_wb_stb_o === 1'b1) begin
        if (w >= delay) begin
          m_wb_ack_i = 1'b1;
          if (ntx < 64) begin
            log_adr[ntx] = m_wb_adr_o;
            log_dat[ntx] = m_wb_dat_o;
          end
          ntx++;
          w = 0;
        end else begin
          w++; pend = 1'b1; padr = m_wb_adr_o; pdat = m_wb_dat_o;
        end
      end
      step();
    end
    m_wb_ack_i = 1'b0; tbl_we = 1'b0; s_req_valid = 1'b0; frame_start = 1'b0;
  endtask
  task automatic check_log(input string tag, input int mul, input int ofs);
    n_cmp++;
    if (ntx !== 28) begin
      n_fail++;
      $display("FAIL %s_count: transfers=%0d required 28", tag, ntx);
    end
    for (int i = 0; i < 27; i++) begin
      n_cmp++;
      if (log_adr[i] !== 8'(8'h40 + i) || log_dat[i] !== 32'(i * mul + ofs)) begin
        n_fail++;
        $display("FAIL %s_word%0d: adr=%h dat=%h required adr=%h dat=%h", tag, i,
                 log_adr[i], log_dat[i], 8'(8'h40 + i), 32'(i * mul + ofs));
      end
    end
    n_cmp++;
    if (log_adr[27] !== 8'h04 || log_dat[27] !== 32'h3) begin
      n_fail++;
      $display("FAIL %s_ctl: adr=%h dat=%h required adr=04 dat=00000003", tag, log_adr[27], log_dat[27]);
    end
  endtask
  task automatic test_reset();
    n_cmp++;
    if ({s_req_ready, update_req, m_wb_stb_o, busy, done} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: ready,upd,stb,busy,done=%b required 10000",
               {s_req_ready, update_req, m_wb_stb_o, busy, done});
    end
    n_cmp++;
    if (m_wb_adr_o !== 8'h0 || m_wb_dat_o !== 32'h0 || active_bank !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_vals: adr=%h dat=%h bank=%0d required 0", m_wb_adr_o, m_wb_dat_o, active_bank);
    end
  endtask
  task automatic test_basic();
    request(2'd1);
    n_cmp++;
    if (m_wb_stb_o !== 1'b1 || m_wb_we_o !== 1'b1 || m_wb_sel_o !== 4'hF || busy !== 1'b1 || s_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_start: stb=%b we=%b sel=%h busy=%b ready=%b required 1 1 F 1 0",
               m_wb_stb_o, m_wb_we_o, m_wb_sel_o, busy, s_req_ready);
    end
    serve(0, 200, 0, 0);
    check_log("basic", 1, -13);
    n_cmp++;
    if (update_req !== 1'b1 || m_wb_stb_o !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wait: upd=%b stb=%b done=%b required 1 0 0", update_req, m_wb_stb_o, done);
    end
  endtask
  task automatic test_frame(input logic [1:0] b);
    pulse_frame();
    n_cmp++;
    if (update_req !== 1'b0 || done !== 1'b1 || active_bank !== b || s_req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_commit: upd=%b done=%b bank=%0d ready=%b busy=%b required 0 1 %0d 1 0",
               update_req, done, active_bank, s_req_ready, busy, b);
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_pulse: done=%b required 0", done);
    end
  endtask
  task automatic test_delayed_ack();
    request(2'd2);
    serve(3, 1000, 0, 0);
    check_log("delayed", 100, 0);
    n_cmp++;
    if (stable_err !== 0) begin
      n_fail++;
      $display("FAIL delayed_stable: unstable_cycles=%0d required 0", stable_err);
    end
    test_frame(2'd2);
  endtask
  task automatic test_ignore();
    request(2'd1);
    serve(0, 200, 5, 1);
    check_log("ignore", 1, -13);
    repeat (3) step();
    n_cmp++;
    if (update_req !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_wait: upd=%b done=%b busy=%b required 1 0 1", update_req, done, busy);
    end
    test_frame(2'd1);
  endtask
  task automatic test_reset_mid();
    request(2'd1);
    serve(0, 200, 10, 3);
    n_cmp++;
    if (m_wb_stb_o !== 1'b0 || busy !== 1'b0 || update_req !== 1'b0 || s_req_ready !== 1'b1 || m_wb_adr_o !== 8'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: stb=%b busy=%b upd=%b ready=%b adr=%h required 0 0 0 1 00",
               m_wb_stb_o, busy, update_req, s_req_ready, m_wb_adr_o);
    end
    n_cmp++;
    if (active_bank !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_bank: active_bank=%0d required 0", active_bank);
    end
    step();
    reset = 1'b0;
    request(2'd1);
    n_cmp++;
    if (m_wb_adr_o !== 8'h40 || m_wb_dat_o !== 32'hFFFFFFF3 || m_wb_stb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_restart: adr=%h dat=%h stb=%b required 40 fffffff3 1", m_wb_adr_o, m_wb_dat_o, m_wb_stb_o);
    end
    serve(0, 200, 0, 0);
    check_log("restart", 1, -13);
    test_frame(2'd1);
  endtask
  task automatic test_overwrite();
    request(2'd1);
    serve(0, 200, 5, 2);
    n_cmp++;
    if (log_adr[20] !== 8'h54 || log_dat[20] !== 32'h7) begin
      n_fail++;
      $display("FAIL overwrite_word20: adr=%h dat=%h required 54 00000007", log_adr[20], log_dat[20]);
    end
    n_cmp++;
    if (log_dat[19] !== 32'h6 || log_dat[21] !== 32'h8 || ntx !== 28) begin
      n_fail++;
      $display("FAIL overwrite_neighbours: d19=%h d21=%h n=%0d required 6 8 28", log_dat[19], log_dat[21], ntx);
    end
    test_frame(2'd1);
  endtask
  initial begin
    reset = 1'b1; tbl_we = 1'b0; tbl_bank = '0; tbl_index = '0; tbl_data = '0;
    s_req_bank = '0; s_req_valid = 1'b0; frame_start = 1'b0; m_wb_ack_i = 1'b0;
    repeat (3) step();
    test_reset();
    reset = 1'b0;
    load_bank(2'd1, 1, -13);
    load_bank(2'd2, 100, 0);
    test_basic();
    repeat (2) step();
    test_frame(2'd1);
    test_delayed_ack();
    test_ignore();
    test_reset_mid();
    test_overwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
